hex_scan_display: RTL and testbench



---
 rtl/hex_scan_pkg.sv | 28 ++
 rtl/seg7_decode.sv | 37 +++
 rtl/hex_scan_display.sv | 125 ++++++++++++
 tb/tb_hex_scan_display.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/hex_scan_pkg.sv
// Shared constants, types and helpers for the scanned seven-segment controller.
package hex_scan_pkg;

  typedef enum logic [1:0] {
    MODE_HEX   = 2'b00,
    MODE_BCD   = 2'b01,
    MODE_COUNT = 2'b10,
    MODE_BLINK = 2'b11
  } mode_e;

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } phase_e;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Counter width for a 0..n-1 prescaler; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    if (n > 1) w = $clog2(n);
    return w;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low seven-segment glyph; BCD mode dashes out 10..15.
module seg7_decode
  import hex_scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       bcd_i,
  output logic [6:0] seg_o
);

  // Glyph lookup with BCD out-of-range override
  always_comb begin
    seg_o = SEG_OFF;
    if (bcd_i && (nibble_i > 4'd9)) begin
      seg_o = SEG_DASH;
    end else begin
      case (nibble_i)
        4'h0: seg_o = 7'h40;
        4'h1: seg_o = 7'h79;
        4'h2: seg_o = 7'h24;
        4'h3: seg_o = 7'h30;
        4'h4: seg_o = 7'h19;
        4'h5: seg_o = 7'h12;
        4'h6: seg_o = 7'h02;
        4'h7: seg_o = 7'h78;
        4'h8: seg_o = 7'h00;
        4'h9: seg_o = 7'h10;
        4'hA: seg_o = 7'h08;
        4'hB: seg_o = 7'h03;
        4'hC: seg_o = 7'h46;
        4'hD: seg_o = 7'h21;
        4'hE: seg_o = 7'h06;
        4'hF: seg_o = 7'h0E;
      endcase
    end
  end

endmodule

// File: rtl/hex_scan_display.sv
// Time-multiplexed multi-digit seven-segment controller with hex, BCD,
// up-counter and blinking-hex modes. Outputs are registered.
module hex_scan_display
  import hex_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned CNT_DIV    = 5000000,
  parameter int unsigned BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic                    load,
  output logic [6:0]              hex,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int unsigned IW = cnt_width(NUM_DIGITS);
  localparam int unsigned SW = cnt_width(SCAN_DIV);
  localparam int unsigned CW = cnt_width(CNT_DIV);
  localparam int unsigned BW = cnt_width(BLINK_DIV);
  localparam int unsigned VW = 4 * NUM_DIGITS;

  mode_e            mode_cur, mode_q;
  logic [SW-1:0]    scan_q, scan_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cpre_q, cpre_d;
  logic [BW-1:0]    bpre_q, bpre_d, bpre_eff;
  phase_e           phase_q, phase_d, phase_eff;
  logic [VW-1:0]    shadow_q, shadow_d;
  logic [VW-1:0]    cnt_q, cnt_d;
  logic [6:0]       hex_q, hex_d;
  logic [NUM_DIGITS-1:0] an_q, an_d, an_sel;
  logic [VW-1:0]    src;
  logic [3:0]       nib;
  logic [6:0]       glyph;
  logic             scan_tc, cnt_tc, blink_tc, blink_entry, blank;

  assign mode_cur = mode_e'(mode);

  // Prescalers, scan index, shadow/counter and blink phase next-state
  always_comb begin
    scan_tc = (scan_q == SW'(SCAN_DIV - 1));
    scan_d  = scan_tc ? '0 : scan_q + 1'b1;
    idx_d   = idx_q;
    if (scan_tc) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;

    cnt_tc = (cpre_q == CW'(CNT_DIV - 1));
    cpre_d = cnt_tc ? '0 : cpre_q + 1'b1;
    cnt_d  = cnt_q;
    if (load) cnt_d = data;
    else if (cnt_tc && (mode_cur == MODE_COUNT)) cnt_d = cnt_q + 1'b1;

    shadow_d = load ? data : shadow_q;

    // The entry cycle behaves as count 0 of an on phase, so the first
    // on-half after switching to blink is a full BLINK_DIV cycles long.
    blink_entry = (mode_cur == MODE_BLINK) && (mode_q != MODE_BLINK);
    bpre_eff    = blink_entry ? '0 : bpre_q;
    phase_eff   = blink_entry ? PHASE_ON : phase_q;
    blink_tc    = (bpre_eff == BW'(BLINK_DIV - 1));
    bpre_d      = blink_tc ? '0 : bpre_eff + 1'b1;
    phase_d     = phase_eff;
    if (blink_tc) phase_d = (phase_eff == PHASE_ON) ? PHASE_OFF : PHASE_ON;
  end

  // Select the scanned nibble and its anode
  always_comb begin
    src    = (mode_cur == MODE_COUNT) ? cnt_q : shadow_q;
    nib    = src[3:0];
    an_sel = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib       = src[4*i +: 4];
        an_sel[i] = 1'b0;
      end
    end
  end

  seg7_decode u_dec (
    .nibble_i (nib),
    .bcd_i    (mode_cur == MODE_BCD),
    .seg_o    (glyph)
  );

  // Output next-state with blink blanking
  always_comb begin
    blank = (mode_cur == MODE_BLINK) && (phase_eff == PHASE_OFF);
    hex_d = blank ? SEG_OFF : glyph;
    an_d  = blank ? '1 : an_sel;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q   <= '0;
      idx_q    <= '0;
      cpre_q   <= '0;
      bpre_q   <= '0;
      phase_q  <= PHASE_ON;
      mode_q   <= MODE_HEX;
      shadow_q <= '0;
      cnt_q    <= '0;
      hex_q    <= SEG_OFF;
      an_q     <= '1;
    end else begin
      scan_q   <= scan_d;
      idx_q    <= idx_d;
      cpre_q   <= cpre_d;
      bpre_q   <= bpre_d;
      phase_q  <= phase_d;
      mode_q   <= mode_cur;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      hex_q    <= hex_d;
      an_q     <= an_d;
    end
  end

  assign hex = hex_q;
  assign an  = an_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Scoreboard bench for hex_scan_display (4 digits, small dividers).
module tb_hex_scan_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic [15:0] data = '0;
  logic        load = 1'b0;
  logic [6:0]  hex;
  logic [3:0]  an;

  hex_scan_display #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (4),
    .CNT_DIV    (8),
    .BLINK_DIV  (16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .data (data),
    .load (load),
    .hex  (hex),
    .an   (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [6:0]  hex;
    logic [3:0]  an;
    string       name;
  } entry_t;

  entry_t      sb[$];
  entry_t      e;
  int unsigned cyc = 0;
  int unsigned base = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  localparam logic [3:0] AN_T    [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [6:0] G_B530  [4] = '{7'h40, 7'h30, 7'h12, 7'h03};
  localparam logic [6:0] G_9F31B [4] = '{7'h79, 7'h30, 7'h3F, 7'h10};

  // Edge counter: after posedge n, cyc == n
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every due expectation against the sampled outputs
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_tests++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
      end else if (hex !== e.hex || an !== e.an) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got hex=%h an=%b, expected hex=%h an=%b",
                 e.name, cyc, hex, an, e.hex, e.an);
      end
    end
  end

  function automatic void expect_at(int unsigned c, logic [6:0] h, logic [3:0] a, string nm);
    entry_t x;
    x.cyc = c; x.hex = h; x.an = a; x.name = nm;
    sb.push_back(x);
  endfunction

  function automatic int unsigned dig(int unsigned k);
    return ((k - 1) / 4) % 4;
  endfunction

  task automatic go_to(int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    load = 1'b0;
    expect_at(cyc + 1, 7'h7F, 4'hF, "reset");
    expect_at(cyc + 2, 7'h7F, 4'hF, "reset");
    go_to(cyc + 2);
    rst  = 1'b0;
    base = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Hex scan over one frame
    do_reset();
    mode = 2'b00; data = 16'hB530; load = 1'b1;
    for (int unsigned k = 1; k <= 16; k++) expect_at(base + k, G_B530[dig(k)], AN_T[dig(k)], "hex_frame");
    go_to(base + 1); load = 1'b0;
    go_to(base + 16);

    // BCD with dash; load visible two cycles after the strobe
    mode = 2'b01; data = 16'h9F31; load = 1'b1;
    expect_at(base + 17, 7'h40, 4'b1110, "bcd_preload");
    for (int unsigned k = 18; k <= 32; k++) expect_at(base + k, G_9F31B[dig(k)], AN_T[dig(k)], "bcd_frame");
    go_to(base + 17); load = 1'b0;
    go_to(base + 32);

    // Counter wrap, then load coincident with a tick
    do_reset();
    mode = 2'b10; data = 16'hFFFF; load = 1'b1;
    expect_at(base + 1, 7'h40, 4'b1110, "cnt_before_load");
    for (int unsigned k = 2;  k <= 8;  k++) expect_at(base + k, 7'h0E, AN_T[dig(k)], "cnt_ffff");
    for (int unsigned k = 9;  k <= 16; k++) expect_at(base + k, 7'h40, AN_T[dig(k)], "cnt_wrap");
    for (int unsigned k = 17; k <= 20; k++) expect_at(base + k, 7'h79, AN_T[dig(k)], "cnt_one");
    for (int unsigned k = 21; k <= 32; k++) expect_at(base + k, 7'h40, AN_T[dig(k)], "cnt_upper");
    go_to(base + 1); load = 1'b0;
    go_to(base + 31); data = 16'h0005; load = 1'b1;
    for (int unsigned k = 33; k <= 36; k++) expect_at(base + k, 7'h12, AN_T[dig(k)], "cnt_load_wins");
    for (int unsigned k = 37; k <= 48; k++) expect_at(base + k, 7'h40, AN_T[dig(k)], "cnt_upper2");
    for (int unsigned k = 49; k <= 52; k++) expect_at(base + k, 7'h78, AN_T[dig(k)], "cnt_after_load");
    go_to(base + 32); load = 1'b0;
    go_to(base + 52);

    // Blink entered after the free-running phase has gone off
    do_reset();
    mode = 2'b00; data = 16'hB530; load = 1'b1;
    for (int unsigned k = 1; k <= 20; k++) expect_at(base + k, G_B530[dig(k)], AN_T[dig(k)], "blink_pre");
    go_to(base + 1); load = 1'b0;
    go_to(base + 20); mode = 2'b11;
    for (int unsigned k = 21; k <= 36; k++) expect_at(base + k, G_B530[dig(k)], AN_T[dig(k)], "blink_on");
    for (int unsigned k = 37; k <= 52; k++) expect_at(base + k, 7'h7F, 4'hF, "blink_off");
    for (int unsigned k = 53; k <= 56; k++) expect_at(base + k, G_B530[dig(k)], AN_T[dig(k)], "blink_resume");
    go_to(base + 56);

    // Mid-frame reset in COUNT mode
    do_reset();
    mode = 2'b10; data = 16'h1234; load = 1'b1;
    expect_at(base + 1, 7'h40, 4'b1110, "rst_cnt_first");
    for (int unsigned k = 2; k <= 4; k++) expect_at(base + k, 7'h19, AN_T[dig(k)], "rst_cnt_d0");
    for (int unsigned k = 5; k <= 6; k++) expect_at(base + k, 7'h30, AN_T[dig(k)], "rst_cnt_d1");
    go_to(base + 1); load = 1'b0;
    go_to(base + 6); rst = 1'b1;
    expect_at(base + 7, 7'h7F, 4'hF, "midframe_rst");
    expect_at(base + 8, 7'h7F, 4'hF, "midframe_rst_hold");
    go_to(base + 8); rst = 1'b0;
    base = cyc;
    for (int unsigned k = 1; k <= 8; k++) expect_at(base + k, 7'h40, AN_T[dig(k)], "post_rst_cnt0");
    go_to(base + 10);

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
